fdiv_writeback: RTL and testbench

- Downstream neighbour of the pipelined FP divider. Tracks the destination register tag of each divide through the divider's three en-gated stages (e1/e2/e3), alongside the datapath.
- Captures the divider's combinational result when stage e3 retires and classifies it (NaN / infinity / zero).
- Buffers results in a small FIFO that drains to the FP register-file write port through a valid/ready handshake.
- Provides back-pressure to the pipeline enable logic and RAW-hazard detection for the decode stage.

---
 rtl/fdiv_writeback.sv | 141 ++++++++++++++
 tb/tb_fdiv_writeback.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_writeback.sv
// fdiv_writeback: follows divide destination tags through e1..e3, classifies
// the retiring result and queues it for the FP register-file write port.
module fdiv_writeback #(
    parameter int DEPTH  = 2,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [31:0]       div_result,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic [2:0]        wb_flags,
    output logic              hold_out,
    input  logic [4:0]        q_rs,
    input  logic [4:0]        q_rt,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic [PEND_W-1:0] pending,
    output logic              err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          v1, v2, v3;
    logic [4:0]    rd1, rd2, rd3;
    logic [4:0]    mem_rd    [DEPTH];
    logic [31:0]   mem_data  [DEPTH];
    logic [2:0]    mem_flags [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    logic [4:0]    last_rd;
    logic [31:0]   last_data;
    logic [2:0]    last_flags;

    logic [7:0]  res_exp;
    logic [22:0] res_frac;
    logic [2:0]  res_flags;
    logic        push, pop, wr, full_eff;
    logic [DEPTH-1:0] ent_v;

    assign res_exp   = div_result[30:23];
    assign res_frac  = div_result[22:0];
    assign res_flags = {(res_exp == 8'hff) && (res_frac != 23'd0),
                        (res_exp == 8'hff) && (res_frac == 23'd0),
                        (res_exp == 8'h00) && (res_frac == 23'd0)};

    assign wb_valid = (count != '0);
    assign full_eff = (count == FULL_CNT) && !wb_ready;
    assign push     = v3 && en;
    assign pop      = wb_valid && wb_ready;
    assign wr       = push && !full_eff;
    assign hold_out = v3 && full_eff;

    // Once drained, the head outputs keep showing the last popped entry.
    assign wb_rd    = wb_valid ? mem_rd[rptr]    : last_rd;
    assign wb_data  = wb_valid ? mem_data[rptr]  : last_data;
    assign wb_flags = wb_valid ? mem_flags[rptr] : last_flags;

    assign pending = PEND_W'(v1) + PEND_W'(v2) + PEND_W'(v3) + PEND_W'(count);

    always_comb begin
        count_nxt = count;
        unique case ({wr, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        logic [AW-1:0] off;
        off   = '0;
        ent_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = AW'(i) - rptr;
            ent_v[i] = (CW'(off) < count);
        end
    end

    always_comb begin
        hazard_rs = (v1 && rd1 == q_rs) || (v2 && rd2 == q_rs) ||
                    (v3 && rd3 == q_rs);
        hazard_rt = (v1 && rd1 == q_rt) || (v2 && rd2 == q_rt) ||
                    (v3 && rd3 == q_rt);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i] && mem_rd[i] == q_rs) hazard_rs = 1'b1;
            if (ent_v[i] && mem_rd[i] == q_rt) hazard_rt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_rd[wptr]    <= rd3;
            mem_data[wptr]  <= div_result;
            mem_flags[wptr] <= res_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            rd1        <= '0;
            rd2        <= '0;
            rd3        <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            err        <= 1'b0;
            last_rd    <= '0;
            last_data  <= '0;
            last_flags <= '0;
        end else begin
            if (en) begin
                v1  <= issue_valid;
                rd1 <= issue_rd;
                v2  <= v1;
                rd2 <= rd1;
                v3  <= v2;
                rd3 <= rd2;
            end
            if (wr) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr       <= rptr + 1'b1;
                last_rd    <= mem_rd[rptr];
                last_data  <= mem_data[rptr];
                last_flags <= mem_flags[rptr];
            end
            count <= count_nxt;
            // en forced through a hold loses the e3 entry.
            if (push && full_eff) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fdiv_writeback.sv
// tb_fdiv_writeback: vector table, directed corner sequences and a
// randomized run against a queue-based model of the writeback block.
module tb_fdiv_writeback;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, en, issue_valid, wb_ready;
    logic [4:0]  issue_rd, q_rs, q_rt;
    logic [31:0] div_result;
    logic        wb_valid, hold_out, hazard_rs, hazard_rt, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  wb_flags;
    logic [3:0]  pending;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fdiv_writeback #(.DEPTH(DEPTH), .PEND_W(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .div_result(div_result), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_flags(wb_flags), .hold_out(hold_out),
        .q_rs(q_rs), .q_rt(q_rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .pending(pending), .err(err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        int         age;
    } pipe_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  fl;
    } ent_t;

    vec_t  vt[8];
    pipe_t pq[$];
    pipe_t nq[$];
    ent_t  fq[$];
    ent_t  m_last;
    bit    m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        en          = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        wb_ready    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Three back-to-back divides rd 1,2,3 with the write port blocked;
    // ends with rd1/rd2 buffered and rd3 sitting in e3.
    task automatic fill3();
        do_reset();
        div_result = 32'h40000000;
        en = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1;
            issue_rd    = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [2:0] classify(input logic [31:0] r);
        logic [7:0]  e = r[30:23];
        logic [22:0] f = r[22:0];
        if (e == 8'hff) return (f != 0) ? 3'b100 : 3'b010;
        if (e == 8'h00 && f == 0) return 3'b001;
        return 3'b000;
    endfunction

    initial begin
        bit          in_e3, m_hold, m_hz_rs, m_hz_rt, full, trig;
        logic [31:0] r;
        int          k;

        vt[0] = '{5'd7,  32'h3fc00000, 3'b000};
        vt[1] = '{5'd4,  32'h7fc00000, 3'b100};
        vt[2] = '{5'd5,  32'hff800000, 3'b010};
        vt[3] = '{5'd6,  32'h80000000, 3'b001};
        vt[4] = '{5'd0,  32'h00000000, 3'b001};
        vt[5] = '{5'd31, 32'h7f800001, 3'b100};
        vt[6] = '{5'd8,  32'h00000001, 3'b000};
        vt[7] = '{5'd9,  32'h7f7fffff, 3'b000};

        q_rs = 5'd0;
        q_rt = 5'd0;
        div_result = 32'h0;
        do_reset();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_flags", wb_flags, 0);
        chk("rst_pending", pending, 0);
        chk("rst_hold", hold_out, 0);
        chk("rst_hz_rs", hazard_rs, 0);
        chk("rst_hz_rt", hazard_rt, 0);
        chk("rst_err", err, 0);

        // Single op: wb_valid four cycles after issue.
        en = 1'b1;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        div_result = 32'h3fc00000;
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("single_pending", pending, 1);
            chk("single_valid", wb_valid, (c == 4) ? 1 : 0);
            if (c < 4) tick();
        end
        chk("single_rd", wb_rd, 7);
        chk("single_data", wb_data, 32'h3fc00000);
        chk("single_flags", wb_flags, 3'b000);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("single_pop_pending", pending, 0);
        chk("single_pop_valid", wb_valid, 0);
        chk("single_hold_rd", wb_rd, 7);

        // Vector table: classification of the captured result.
        for (int i = 0; i < 8; i++) begin
            div_result = vt[i].res;
            issue_rd = vt[i].rd;
            issue_valid = 1'b1;
            en = 1'b1;
            tick();
            issue_valid = 1'b0;
            tick();
            tick();
            tick();
            chk("vec_valid", wb_valid, 1);
            chk("vec_rd", wb_rd, vt[i].rd);
            chk("vec_data", wb_data, vt[i].res);
            chk("vec_flags", wb_flags, vt[i].fl);
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
            chk("vec_empty", wb_valid, 0);
        end

        // Stall: five en=0 cycles delay writeback by five.
        do_reset();
        q_rs = 5'd3;
        en = 1'b1;
        issue_valid = 1'b1;
        issue_rd = 5'd3;
        tick();
        issue_valid = 1'b0;
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_hz", hazard_rs, 1);
            chk("stall_valid", wb_valid, 0);
            tick();
        end
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid2", wb_valid, 0);
            chk("stall_hz2", hazard_rs, 1);
            tick();
        end
        chk("stall_valid3", wb_valid, 1);
        chk("stall_rd", wb_rd, 3);
        chk("stall_hz3", hazard_rs, 1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("stall_hz_after", hazard_rs, 0);

        // Back-pressure honoured by the pipeline.
        fill3();
        en = 1'b0;
        chk("bp_hold", hold_out, 1);
        chk("bp_pending", pending, 3);
        chk("bp_head", wb_rd, 1);
        tick();
        chk("bp_hold2", hold_out, 1);
        chk("bp_head2", wb_rd, 1);
        chk("bp_data", wb_data, 32'h40000000);
        wb_ready = 1'b1;
        #1;
        chk("bp_hold_rel", hold_out, 0);
        en = 1'b1;
        tick();
        chk("bp_order2", wb_rd, 2);
        chk("bp_pending2", pending, 2);
        tick();
        chk("bp_order3", wb_rd, 3);
        tick();
        chk("bp_drained", wb_valid, 0);
        chk("bp_pending0", pending, 0);
        chk("bp_err", err, 0);

        // Protocol error: en forced high under hold.
        fill3();
        chk("pe_hold", hold_out, 1);
        tick();
        chk("pe_err", err, 1);
        chk("pe_pending", pending, 2);
        chk("pe_head", wb_rd, 1);
        wb_ready = 1'b1;
        tick();
        chk("pe_order2", wb_rd, 2);
        tick();
        chk("pe_empty", wb_valid, 0);
        chk("pe_lastrd", wb_rd, 2);
        en = 1'b0;
        tick();
        chk("pe_err_sticky", err, 1);
        do_reset();
        chk("pe_err_clr", err, 0);

        // Reset mid-operation discards in-flight divides.
        en = 1'b1;
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        tick();
        issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        q_rs = 5'd9;
        q_rt = 5'd10;
        chk("mid_pending_pre", pending, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_pending", pending, 0);
        chk("mid_hz_rs", hazard_rs, 0);
        chk("mid_hz_rt", hazard_rt, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mid_no_wb", wb_valid, 0);
        end

        // Randomized run against the queue model.
        do_reset();
        pq.delete();
        fq.delete();
        m_last = '{5'd0, 32'd0, 3'd0};
        m_err = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            in_e3 = 0;
            foreach (pq[j]) if (pq[j].age == 3) in_e3 = 1;
            m_hold = in_e3 && fq.size() == DEPTH && !wb_ready;
            en = ($urandom_range(0, 7) != 0) &&
                 (!m_hold || $urandom_range(0, 15) == 0);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd = 5'($urandom_range(0, 7));
            q_rs = 5'($urandom_range(0, 7));
            q_rt = 5'($urandom_range(0, 7));
            r = $urandom;
            k = $urandom_range(0, 5);
            if (k == 0) r[30:23] = 8'hff;
            if (k == 1) r[30:23] = 8'h00;
            if (k <= 1 && $urandom_range(0, 1) == 1) r[22:0] = 23'd0;
            div_result = r;
            #1;
            m_hz_rs = 0;
            m_hz_rt = 0;
            foreach (pq[j]) begin
                if (pq[j].rd == q_rs) m_hz_rs = 1;
                if (pq[j].rd == q_rt) m_hz_rt = 1;
            end
            foreach (fq[j]) begin
                if (fq[j].rd == q_rs) m_hz_rs = 1;
                if (fq[j].rd == q_rt) m_hz_rt = 1;
            end
            chk("rnd_hold", hold_out, m_hold);
            chk("rnd_hz_rs", hazard_rs, m_hz_rs);
            chk("rnd_hz_rt", hazard_rt, m_hz_rt);
            if (rst) begin
                pq.delete();
                fq.delete();
                m_last = '{5'd0, 32'd0, 3'd0};
                m_err = 0;
            end else begin
                full = (fq.size() == DEPTH) && !wb_ready;
                trig = (fq.size() > 0) && wb_ready;
                if (trig) m_last = fq.pop_front();
                if (en) begin
                    nq.delete();
                    foreach (pq[j]) begin
                        if (pq[j].age == 3) begin
                            if (full) m_err = 1;
                            else fq.push_back('{pq[j].rd, r, classify(r)});
                        end else begin
                            nq.push_back('{pq[j].rd, pq[j].age + 1});
                        end
                    end
                    if (issue_valid) nq.push_back('{issue_rd, 1});
                    pq = nq;
                end
            end
            tick();
            chk("rnd_valid", wb_valid, fq.size() != 0);
            chk("rnd_rd", wb_rd, (fq.size() != 0) ? fq[0].rd : m_last.rd);
            chk("rnd_data", wb_data, (fq.size() != 0) ? fq[0].data : m_last.data);
            chk("rnd_flags", wb_flags, (fq.size() != 0) ? fq[0].fl : m_last.fl);
            chk("rnd_pending", pending, pq.size() + fq.size());
            chk("rnd_err", err, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
